core_alu_rmw_seq: RTL

- Sequences read-modify-write memory instructions (ASL/LSR/ROL/ROR/INC/DEC on memory) through the shared core ALU and the CPU data bus.
- Accepts one decoded RMW request from the instruction decoder and drives the bus: read, optional dummy write, final write.
- Drives the ALU control word and operands during the modify step, then returns the result and flags to the status-register logic.
- Owns the ALU only while busy; issues control_nop (all zeros) otherwise.

---
 rtl/core_alu_rmw_seq_if.sv | 69 ++++++
 rtl/core_alu_rmw_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_alu_rmw_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_alu_rmw_seq_if
//  Description : Request, data-bus, ALU and response signals of the RMW
//                sequencer. The master modport is the sequencer side; the
//                slave modport is the decoder/bus/ALU/status-logic side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_alu_rmw_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CTL_W  = 19
) ();

  // Request from the instruction decoder
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              req_carry;

  // CPU data bus
  logic              bus_en;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rdy;

  // Shared core ALU
  logic [CTL_W-1:0]  alu_ctl;
  logic [DATA_W-1:0] alu_lhs;
  logic              alu_carry_in;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry_out;

  // Response to the status-register logic
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_n;
  logic              resp_z;
  logic              resp_c;
  logic              resp_err;

  modport master (
    input  req_valid, req_op, req_addr, req_carry,
    output req_ready,
    output bus_en, bus_rw, bus_addr, bus_wdata,
    input  bus_rdata, bus_rdy,
    output alu_ctl, alu_lhs, alu_carry_in,
    input  alu_result, alu_carry_out,
    output resp_valid, resp_data, resp_n, resp_z, resp_c, resp_err,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_op, req_addr, req_carry,
    input  req_ready,
    input  bus_en, bus_rw, bus_addr, bus_wdata,
    output bus_rdata, bus_rdy,
    input  alu_ctl, alu_lhs, alu_carry_in,
    output alu_result, alu_carry_out,
    input  resp_valid, resp_data, resp_n, resp_z, resp_c, resp_err,
    output resp_ready
  );

endinterface
`default_nettype wire

// File: rtl/core_alu_rmw_seq.sv
`default_nettype none
// ============================================================================
//  Module      : core_alu_rmw_seq
//  Description : Read-modify-write sequencer for ASL/LSR/ROL/ROR/INC/DEC on
//                memory. Reads the operand, optionally writes it back
//                unchanged (6502 dummy write), runs it through the shared
//                ALU, writes the result and hands result plus flags to the
//                status-register logic.
//  Options     : CORE_ALU_RMW_DUMMY_WRITE_EN - when defined, the dummy write
//                of the original value is issued between read and final
//                write (cycle-accurate 2A03 bus behaviour).
//  Revision    : 1.0 - initial release
// ============================================================================
module core_alu_rmw_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CTL_W  = 19
) (
  input  wire                 clk,
  input  wire                 rst_n,
  core_alu_rmw_seq_if.master  rmw
);

  // Operation encodings on req_op
  localparam logic [2:0] C_OP_ASL = 3'd0;
  localparam logic [2:0] C_OP_LSR = 3'd1;
  localparam logic [2:0] C_OP_ROL = 3'd2;
  localparam logic [2:0] C_OP_ROR = 3'd3;
  localparam logic [2:0] C_OP_INC = 3'd4;
  localparam logic [2:0] C_OP_DEC = 3'd5;

  // ALU control words for each operation; all-zero is the ALU no-op
  localparam logic [CTL_W-1:0] C_CTL_NOP = '0;
  localparam logic [CTL_W-1:0] C_CTL_ASL = CTL_W'(19'h50046);
  localparam logic [CTL_W-1:0] C_CTL_LSR = CTL_W'(19'h60046);
  localparam logic [CTL_W-1:0] C_CTL_ROL = CTL_W'(19'h50006);
  localparam logic [CTL_W-1:0] C_CTL_ROR = CTL_W'(19'h60006);
  localparam logic [CTL_W-1:0] C_CTL_INC = CTL_W'(19'h00166);
  localparam logic [CTL_W-1:0] C_CTL_DEC = CTL_W'(19'h00266);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_READ         = 3'd1,
    S_DUMMY        = 3'd2,
    S_MODIFY_WRITE = 3'd3,
    S_RESP         = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_carry;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_result;
  logic              r_res_c;
  logic              r_err;
  logic              r_have_result;

  logic              w_accept;
  logic              w_req_reserved;
  logic              w_is_incdec;
  logic [CTL_W-1:0]  w_ctl;

  assign w_accept       = (r_state == S_IDLE) && rmw.req_valid;
  assign w_req_reserved = (rmw.req_op > C_OP_DEC);
  assign w_is_incdec    = (r_op == C_OP_INC) || (r_op == C_OP_DEC);

  // Select the ALU control word for the latched operation
  always_comb begin
    w_ctl = C_CTL_NOP;
    case (r_op)
      C_OP_ASL: w_ctl = C_CTL_ASL;
      C_OP_LSR: w_ctl = C_CTL_LSR;
      C_OP_ROL: w_ctl = C_CTL_ROL;
      C_OP_ROR: w_ctl = C_CTL_ROR;
      C_OP_INC: w_ctl = C_CTL_INC;
      C_OP_DEC: w_ctl = C_CTL_DEC;
      default:  w_ctl = C_CTL_NOP;
    endcase
  end

  // State register; reset abandons any bus cycle in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; every bus phase holds until bus_rdy, RESP until resp_ready
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rmw.req_valid) begin
          w_state_nxt = w_req_reserved ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        if (rmw.bus_rdy) begin
`ifdef CORE_ALU_RMW_DUMMY_WRITE_EN
          w_state_nxt = S_DUMMY;
`else
          w_state_nxt = S_MODIFY_WRITE;
`endif
        end
      end
`ifdef CORE_ALU_RMW_DUMMY_WRITE_EN
      S_DUMMY: begin
        if (rmw.bus_rdy) begin
          w_state_nxt = S_MODIFY_WRITE;
        end
      end
`endif
      S_MODIFY_WRITE: begin
        if (rmw.bus_rdy) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rmw.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request/bus/response outputs decoded from the current state
  always_comb begin
    rmw.req_ready  = 1'b0;
    rmw.bus_en     = 1'b0;
    rmw.bus_rw     = 1'b1;
    rmw.bus_addr   = '0;
    rmw.bus_wdata  = '0;
    rmw.resp_valid = 1'b0;
    rmw.resp_data  = '0;
    rmw.resp_n     = 1'b0;
    rmw.resp_z     = 1'b0;
    rmw.resp_c     = 1'b0;
    rmw.resp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        rmw.req_ready = 1'b1;
      end
      S_READ: begin
        rmw.bus_en   = 1'b1;
        rmw.bus_addr = r_addr;
      end
`ifdef CORE_ALU_RMW_DUMMY_WRITE_EN
      S_DUMMY: begin
        rmw.bus_en    = 1'b1;
        rmw.bus_rw    = 1'b0;
        rmw.bus_addr  = r_addr;
        rmw.bus_wdata = r_data;
      end
`endif
      S_MODIFY_WRITE: begin
        rmw.bus_en   = 1'b1;
        rmw.bus_rw   = 1'b0;
        rmw.bus_addr = r_addr;
        // First cycle uses the live ALU result; stall cycles reuse the
        // value captured on that first cycle.
        rmw.bus_wdata = r_have_result ? r_result : rmw.alu_result;
      end
      S_RESP: begin
        rmw.resp_valid = 1'b1;
        rmw.resp_data  = r_result;
        rmw.resp_err   = r_err;
        rmw.resp_n     = !r_err && r_result[DATA_W-1];
        rmw.resp_z     = !r_err && (r_result == '0);
        rmw.resp_c     = !r_err && r_res_c;
      end
      default: begin
        rmw.req_ready = 1'b0;
      end
    endcase
  end

  // Drive the ALU only in the modify step; no-op control word otherwise
  always_comb begin
    rmw.alu_ctl      = C_CTL_NOP;
    rmw.alu_lhs      = '0;
    rmw.alu_carry_in = 1'b0;
    if (r_state == S_MODIFY_WRITE) begin
      rmw.alu_ctl      = w_ctl;
      rmw.alu_lhs      = r_data;
      rmw.alu_carry_in = r_carry;
    end
  end

  // Datapath: latch the request, the read data and the first ALU result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= '0;
      r_addr        <= '0;
      r_carry       <= 1'b0;
      r_data        <= '0;
      r_result      <= '0;
      r_res_c       <= 1'b0;
      r_err         <= 1'b0;
      r_have_result <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op          <= rmw.req_op;
        r_addr        <= rmw.req_addr;
        r_carry       <= rmw.req_carry;
        r_err         <= w_req_reserved;
        r_data        <= '0;
        r_result      <= '0;
        r_res_c       <= 1'b0;
        r_have_result <= 1'b0;
      end
      if ((r_state == S_READ) && rmw.bus_rdy) begin
        r_data <= rmw.bus_rdata;
      end
      if ((r_state == S_MODIFY_WRITE) && !r_have_result) begin
        r_result      <= rmw.alu_result;
        // INC/DEC leave C untouched, so report the carry we came in with
        r_res_c       <= w_is_incdec ? r_carry : rmw.alu_carry_out;
        r_have_result <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
